// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory bus bundled for the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W/8-1:0] m1_wstrb;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a fetch and a load/store requester, one
// transaction at a time, with a watchdog that aborts accesses the memory never answers.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              sel, done, tmo;
  // sel=1 picks m1; on contention round-robin hands the tie to whoever did not win last
  assign sel  = (bus.m0_req & bus.m1_req) ? (RR_EN ? ~last_q : 1'b1) : bus.m1_req;
  assign done = (state_q == WAIT) & bus.mem_rvalid;
  assign tmo  = (state_q == WAIT) & ~bus.mem_rvalid & (timer_q == TW'(TIMEOUT - 1));
  assign bus.m0_gnt    = (state_q == IDLE) & bus.m0_req & ~sel;
  assign bus.m1_gnt    = (state_q == IDLE) & bus.m1_req & sel;
  assign bus.m0_rvalid = (done | tmo) & ~owner_q;
  assign bus.m1_rvalid = (done | tmo) & owner_q;
  assign bus.m0_err    = tmo & ~owner_q;
  assign bus.m1_err    = tmo & owner_q;
  assign bus.m0_rdata  = (done & ~owner_q) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (done & owner_q) ? bus.mem_rdata : '0;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: if (bus.m0_req | bus.m1_req) begin
        state_d = ISSUE;
        owner_d = sel;
        last_d  = sel;
        req_d   = 1'b1;
        we_d    = sel & bus.m1_we;
        addr_d  = sel ? bus.m1_addr : bus.m0_addr;
        wdata_d = sel ? bus.m1_wdata : '0;
        wstrb_d = sel ? bus.m1_wstrb : '0;
      end
      ISSUE: if (bus.mem_gnt) begin
        state_d = WAIT;
        req_d   = 1'b0;
        timer_d = '0;
      end
      WAIT: begin
        state_d = (done | tmo) ? IDLE : WAIT;
        timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      timer_q <= timer_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against a queue-based model of the
// arbiter; a memory responder and a response monitor check independently.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8, TO = 4;
  typedef struct packed {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } cmd_t;
  typedef struct packed {
    logic          who;
    logic          we;
    logic          err;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } rsp_t;
  logic clk = 1'b0, rst_n = 1'b1, fp_req = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, gnt_pct = 100, k_fix = -1, rs_cnt = 0, rs_k = 0;
  logic dfix_en = 1'b0, force_rv = 1'b0, busy = 1'b0, last = 1'b1, rs_act = 1'b0;
  logic [DW-1:0] dfix = '0, rs_data = '0;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fif ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.master));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0), .TIMEOUT(64)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(fif.master));
  // fixed-priority instance: both ports always asking, memory always answering at once
  assign fif.m0_req     = fp_req;
  assign fif.m1_req     = fp_req;
  assign fif.m0_addr    = '0;
  assign fif.m1_we      = 1'b0;
  assign fif.m1_addr    = '0;
  assign fif.m1_wdata   = '0;
  assign fif.m1_wstrb   = '0;
  assign fif.mem_gnt    = 1'b1;
  assign fif.mem_rvalid = 1'b1;
  assign fif.mem_rdata  = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  initial begin : monitor
    logic s;
    logic [1:0] eg;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_q.delete();
        rsp_q.delete();
        busy = 1'b0;
        last = 1'b1;
      end else begin
        eg = 2'b00;
        s = 1'b0;
        if (!busy && (bif.m0_req || bif.m1_req)) begin
          s = (bif.m0_req && bif.m1_req) ? ~last : bif.m1_req;
          eg = s ? 2'b10 : 2'b01;
        end
        check("grant", 64'({bif.m1_gnt, bif.m0_gnt}), 64'(eg));
        if (eg != 2'b00) begin
          busy = 1'b1;
          last = s;
          cmd_q.push_back(s ? cmd_t'{1'b1, bif.m1_we, bif.m1_addr, bif.m1_wdata, bif.m1_wstrb}
                            : cmd_t'{1'b0, 1'b0, bif.m0_addr, DW'(0), SW'(0)});
        end
        if (bif.m0_rvalid || bif.m1_rvalid) begin
          if (rsp_q.size() == 0) check("unexpected_rvalid", 64'({bif.m1_rvalid, bif.m0_rvalid}), 64'(0));
          else begin
            r = rsp_q.pop_front();
            check("rsp_cycle", 64'(cyc), 64'(r.cyc));
            check("rvalid", 64'({bif.m1_rvalid, bif.m0_rvalid}), 64'(r.who ? 2'b10 : 2'b01));
            check("err", 64'({bif.m1_err, bif.m0_err}), 64'(r.err ? (r.who ? 2'b10 : 2'b01) : 2'b00));
            check("other_rdata", 64'(r.who ? bif.m0_rdata : bif.m1_rdata), 64'(0));
            if (!r.we || r.err) check("rdata", 64'(r.who ? bif.m1_rdata : bif.m0_rdata), 64'(r.data));
            busy = 1'b0;
          end
        end
      end
    end
  end
  initial begin : responder
    cmd_t c;
    int p;
    bif.mem_gnt = 1'b0;
    bif.mem_rvalid = 1'b0;
    bif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bif.mem_gnt = 1'b0;
      bif.mem_rvalid = force_rv;
      bif.mem_rdata = $urandom;
      if (!rst_n) rs_act = 1'b0;
      else if (rs_act) begin
        if (rs_cnt == rs_k) begin
          bif.mem_rvalid = 1'b1;
          bif.mem_rdata = rs_data;
        end
        if (rs_cnt == rs_k || rs_cnt == TO + 1) rs_act = 1'b0;
        rs_cnt++;
      end else if (bif.mem_req) begin
        if (cmd_q.size() == 0) check("unexpected_mem_req", 64'(bif.mem_req), 64'(0));
        else begin
          c = cmd_q[0];
          check("mem_addr", 64'(bif.mem_addr), 64'(c.addr));
          check("mem_we", 64'(bif.mem_we), 64'(c.we));
          check("mem_wstrb", 64'(bif.mem_wstrb), 64'(c.wstrb));
          if (c.who) check("mem_wdata", 64'(bif.mem_wdata), 64'(c.wdata));
          if ($urandom_range(0, 99) < gnt_pct) begin
            bif.mem_gnt = 1'b1;
            c = cmd_q.pop_front();
            p = int'($urandom_range(0, 9));
            // k = WAIT-cycle index of the answer; TO and TO+1 are strays, TO+2 means never
            rs_k = (k_fix >= 0) ? k_fix : (p < 6) ? int'($urandom_range(0, TO - 2)) : TO - 7 + p;
            rs_data = dfix_en ? dfix : DW'($urandom);
            rs_act = 1'b1;
            rs_cnt = 0;
            rsp_q.push_back(rsp_t'{c.who, c.we, rs_k >= TO, (rs_k >= TO) ? DW'(0) : rs_data,
                                   32'(cyc + 1 + ((rs_k < TO) ? rs_k : TO - 1))});
          end
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic req_once(input logic who, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    step();
    if (who) begin
      bif.m1_req = 1'b1;
      bif.m1_we = we;
      bif.m1_addr = a;
      bif.m1_wdata = d;
      bif.m1_wstrb = s;
    end else begin
      bif.m0_req = 1'b1;
      bif.m0_addr = a;
    end
    @(negedge clk);
    for (int i = 0; i < 50 && !(bif.m0_gnt || bif.m1_gnt); i++) @(negedge clk);
    check("req_granted", 64'(bif.m0_gnt || bif.m1_gnt), 64'(1));
    step();
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
    bif.m0_addr = $urandom;
    bif.m1_addr = $urandom;
    bif.m1_wdata = $urandom;
    bif.m1_wstrb = 4'($urandom);
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((busy || rs_act) && i < 200) begin
      step();
      i++;
    end
    check("drain", 64'({busy, rs_act}), 64'(0));
    step();
  endtask
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin : stim
    logic [3:0] rr_got, fp_got;
    int nr, nf;
    rr_got = '0;
    fp_got = '0;
    bif.m0_req = 1'b0;
    bif.m0_addr = '0;
    bif.m1_req = 1'b0;
    bif.m1_we = 1'b0;
    bif.m1_addr = '0;
    bif.m1_wdata = '0;
    bif.m1_wstrb = '0;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", 64'(|{bif.mem_req, bif.mem_we, bif.mem_addr, bif.mem_wdata, bif.mem_wstrb,
             bif.m0_gnt, bif.m0_rvalid, bif.m0_rdata, bif.m0_err,
             bif.m1_gnt, bif.m1_rvalid, bif.m1_rdata, bif.m1_err}), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    k_fix = 0;
    dfix_en = 1'b1;
    dfix = 32'hDEADBEEF;
    req_once(1'b0, 1'b0, 32'h100, '0, '0);
    wait_idle();
    do_reset();
    step();
    bif.m0_req = 1'b1;
    bif.m1_req = 1'b1;
    fp_req = 1'b1;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 60 && (nr < 4 || nf < 4); i++) begin
      @(negedge clk);
      if (nr < 4 && (bif.m0_gnt || bif.m1_gnt)) begin
        rr_got[nr] = bif.m1_gnt;
        nr++;
      end
      if (nf < 4 && (fif.m0_gnt || fif.m1_gnt)) begin
        fp_got[nf] = fif.m1_gnt;
        nf++;
      end
    end
    step();
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
    fp_req = 1'b0;
    check("rr_grant_count", 64'(nr), 64'(4));
    check("rr_order", 64'(rr_got), 64'(4'b1010));
    check("fp_order", 64'(fp_got), 64'(4'b1111));
    wait_idle();
    dfix_en = 1'b0;
    k_fix = 1;
    gnt_pct = 0;
    req_once(1'b1, 1'b1, 32'h8, 32'h12345678, 4'b0011);
    repeat (2) step();
    gnt_pct = 100;
    wait_idle();
    k_fix = TO + 2;
    req_once(1'b1, 1'b0, 32'h40, '0, '0);
    wait_idle();
    k_fix = TO;
    req_once(1'b1, 1'b0, 32'h44, '0, '0);
    wait_idle();
    k_fix = TO + 1;
    req_once(1'b0, 1'b0, 32'h48, '0, '0);
    wait_idle();
    k_fix = TO - 1;
    dfix_en = 1'b1;
    dfix = 32'hCAFEF00D;
    req_once(1'b1, 1'b0, 32'h4C, '0, '0);
    wait_idle();
    dfix_en = 1'b0;
    k_fix = -1;
    gnt_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      step();
      bif.m0_req = 1'($urandom_range(0, 1));
      bif.m1_req = 1'($urandom_range(0, 1));
      bif.m1_we = 1'($urandom_range(0, 1));
      bif.m0_addr = $urandom;
      bif.m1_addr = $urandom;
      bif.m1_wdata = $urandom;
      bif.m1_wstrb = 4'($urandom);
    end
    step();
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
    wait_idle();
    gnt_pct = 100;
    k_fix = TO + 2;
    req_once(1'b0, 1'b0, 32'h200, '0, '0);
    step();
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(|{bif.mem_req, bif.mem_we, bif.mem_addr, bif.mem_wdata, bif.mem_wstrb,
             bif.m0_gnt, bif.m0_rvalid, bif.m0_rdata, bif.m0_err,
             bif.m1_gnt, bif.m1_rvalid, bif.m1_rdata, bif.m1_err}), 64'(0));
    step();
    #1 rst_n = 1'b1;
    force_rv = 1'b1;
    step();
    @(negedge clk);
    check("stray_after_reset", 64'({bif.m1_rvalid, bif.m0_rvalid}), 64'(0));
    step();
    force_rv = 1'b0;
    k_fix = 0;
    req_once(1'b1, 1'b0, 32'h300, '0, '0);
    wait_idle();
    check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
    check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
